// File: rtl/telemetry_uart_packetizer.sv
`default_nettype none
// ============================================================================
// telemetry_uart_packetizer: windowed avg/min/max of an 8-bit sample stream,
// each closed window sent as a 5-byte 8N1 UART frame {A5, avg, min, max, chk}.
// Revision: 1.0
// ============================================================================
module telemetry_uart_packetizer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int WINDOW_LOG2  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic       tx,
  output logic       busy,
  output logic       overrun,
  output logic [7:0] frame_cnt
);

  localparam int         SUM_W     = 8 + WINDOW_LOG2;
  localparam int         BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Window accumulator
  logic [SUM_W-1:0]       sum_q, sum_d;
  logic [WINDOW_LOG2-1:0] cnt_q, cnt_d;
  logic [7:0]             min_q, min_d, max_q, max_d;

  // Frame snapshot and status
  logic [7:0] avg_q, avg_d, mn_q, mn_d, mx_q, mx_d, chk_q, chk_d;
  logic       start_pend_q, start_pend_d;
  logic       overrun_q, overrun_d;

  // Transmitter
  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [2:0]        byte_q, byte_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic [7:0]        fcnt_q, fcnt_d;

  logic             accept;
  logic             win_close;
  logic [SUM_W-1:0] sum_next;
  logic [7:0]       min_next, max_next, avg_next;
  logic             baud_end;
  logic [7:0]       next_byte;

  always_comb begin
    accept    = ena && sample_valid;
    win_close = accept && (cnt_q == '1);
    // sum_q is zero whenever cnt_q is zero, so the first sample needs no special case
    sum_next  = sum_q + SUM_W'(sample_in);
    avg_next  = sum_next[SUM_W-1:WINDOW_LOG2];
    min_next  = ((cnt_q == '0) || (sample_in < min_q)) ? sample_in : min_q;
    max_next  = ((cnt_q == '0) || (sample_in > max_q)) ? sample_in : max_q;

    sum_d = sum_q;
    cnt_d = cnt_q;
    min_d = min_q;
    max_d = max_q;
    if (accept) begin
      min_d = min_next;
      max_d = max_next;
      if (win_close) begin
        sum_d = '0;
        cnt_d = '0;
      end else begin
        sum_d = sum_next;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    avg_d        = avg_q;
    mn_d         = mn_q;
    mx_d         = mx_q;
    chk_d        = chk_q;
    start_pend_d = start_pend_q;
    overrun_d    = overrun_q;
    if ((state_q == S_IDLE) && start_pend_q) begin
      start_pend_d = 1'b0;
    end
    if (win_close) begin
      // The snapshot is only taken while the line is idle; otherwise it is dropped
      if (state_q == S_IDLE) begin
        avg_d        = avg_next;
        mn_d         = min_next;
        mx_d         = max_next;
        chk_d        = SYNC_BYTE ^ avg_next ^ min_next ^ max_next;
        start_pend_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_comb begin
    case (byte_q)
      3'd0:    next_byte = avg_q;
      3'd1:    next_byte = mn_q;
      3'd2:    next_byte = mx_q;
      default: next_byte = chk_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    shreg_d  = shreg_q;
    fcnt_d   = fcnt_q;
    baud_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    case (state_q)
      S_IDLE: begin
        if (start_pend_q) begin
          state_d = S_START;
          baud_d  = '0;
          byte_d  = '0;
          shreg_d = SYNC_BYTE;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (byte_q < 3'd4) begin
            state_d = S_START;
            byte_d  = byte_q + 1'b1;
            shreg_d = next_byte;
          end else begin
            state_d = S_IDLE;
            fcnt_d  = fcnt_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Line level is registered from the next state so tx and busy move together
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q        <= '0;
      cnt_q        <= '0;
      min_q        <= '0;
      max_q        <= '0;
      avg_q        <= '0;
      mn_q         <= '0;
      mx_q         <= '0;
      chk_q        <= '0;
      start_pend_q <= 1'b0;
      overrun_q    <= 1'b0;
      state_q      <= S_IDLE;
      baud_q       <= '0;
      bit_q        <= '0;
      byte_q       <= '0;
      shreg_q      <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      fcnt_q       <= '0;
    end else begin
      sum_q        <= sum_d;
      cnt_q        <= cnt_d;
      min_q        <= min_d;
      max_q        <= max_d;
      avg_q        <= avg_d;
      mn_q         <= mn_d;
      mx_q         <= mx_d;
      chk_q        <= chk_d;
      start_pend_q <= start_pend_d;
      overrun_q    <= overrun_d;
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      byte_q       <= byte_d;
      shreg_q      <= shreg_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      fcnt_q       <= fcnt_d;
    end
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign frame_cnt = fcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_telemetry_uart_packetizer.sv
`default_nettype none
// Bench for telemetry_uart_packetizer: a UART monitor decodes every frame off
// tx; frames are compared against table vectors and a window-statistics model.
module tb_telemetry_uart_packetizer;

  localparam int CPB   = 4;
  localparam int WL2   = 2;
  localparam int NS    = 1 << WL2;
  localparam int FRAME = 50 * CPB;

  typedef logic [NS-1:0][7:0] win_t;
  typedef struct packed {
    win_t        s;
    logic [39:0] exp;
  } vec_t;
  typedef struct packed {
    logic [39:0] bytes;
    logic [31:0] start;
    logic        framing_ok;
    logic        busy_ok;
  } rx_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] sample_in = 8'd0;
  logic       sample_valid = 1'b0;
  logic       tx, busy, overrun;
  logic [7:0] frame_cnt;

  telemetry_uart_packetizer #(
    .CLKS_PER_BIT(CPB),
    .WINDOW_LOG2 (WL2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .tx          (tx),
    .busy        (busy),
    .overrun     (overrun),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_fc = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic win_t mk(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
    win_t w;
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    return w;
  endfunction

  function automatic logic [39:0] model(input win_t w);
    int sum = 0;
    int mn  = 255;
    int mx  = 0;
    int avg;
    logic [7:0] a, n, x;
    for (int i = 0; i < NS; i++) begin
      sum += int'(w[i]);
      if (int'(w[i]) < mn) mn = int'(w[i]);
      if (int'(w[i]) > mx) mx = int'(w[i]);
    end
    avg = sum / NS;
    a = 8'(avg); n = 8'(mn); x = 8'(mx);
    return {8'hA5, a, n, x, 8'hA5 ^ a ^ n ^ x};
  endfunction

  // Monitor: samples tx/busy 2 time units after each rising edge
  rx_t  got_q[$];
  logic tx_h   [0:FRAME];
  logic busy_h [0:FRAME];
  bit   mon_act   = 1'b0;
  int   mon_t     = 0;
  int   mon_start = 0;

  function automatic rx_t decode(input int start);
    rx_t  r;
    logic v;
    r.bytes = '0; r.start = 32'(start); r.framing_ok = 1'b1; r.busy_ok = 1'b1;
    for (int b = 0; b < 5; b++) begin
      for (int j = 0; j < 10; j++) begin
        v = tx_h[(10 * b + j) * CPB + CPB / 2];
        for (int k = 0; k < CPB; k++)
          if (tx_h[(10 * b + j) * CPB + k] !== v) r.framing_ok = 1'b0;
        if (j == 0 && v !== 1'b0) r.framing_ok = 1'b0;
        else if (j == 9 && v !== 1'b1) r.framing_ok = 1'b0;
        else if (j > 0 && j < 9) r.bytes[(4 - b) * 8 + (j - 1)] = v;
      end
    end
    if (tx_h[FRAME] !== 1'b1) r.framing_ok = 1'b0;
    for (int t = 0; t <= FRAME; t++)
      if (busy_h[t] !== (t < FRAME)) r.busy_ok = 1'b0;
    return r;
  endfunction

  always begin
    @(posedge clk);
    #2;
    cyc = cyc + 1;
    if (!rst_n) begin
      mon_act = 1'b0;
    end else begin
      if (!mon_act && tx === 1'b0) begin
        mon_act = 1'b1; mon_t = 0; mon_start = cyc;
      end
      if (mon_act) begin
        tx_h[mon_t] = tx; busy_h[mon_t] = busy; mon_t++;
        if (mon_t > FRAME) begin
          got_q.push_back(decode(mon_start));
          mon_act = 1'b0;
        end
      end
    end
  end

  task automatic drive(input logic [7:0] v, input logic en, input logic vld);
    @(negedge clk);
    sample_in = v; ena = en; sample_valid = vld;
  endtask

  task automatic finish_drive(output int close);
    @(negedge clk);
    sample_valid = 1'b0;
    close = cyc;
  endtask

  task automatic send_window(input win_t w, output int close);
    for (int i = 0; i < NS; i++) drive(w[i], 1'b1, 1'b1);
    finish_drive(close);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic expect_frame(input string tag, input logic [39:0] exp, input int close);
    rx_t r;
    int  n = 0;
    while (got_q.size() == 0 && n < 2 * FRAME + 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (got_q.size() == 0) begin
      errors++;
      $display("FAIL %s timeout: no frame within %0d cycles", tag, n);
      return;
    end
    r = got_q.pop_front();
    exp_fc++;
    check({tag, " bytes"}, r.bytes, exp);
    check({tag, " latency"}, 64'(r.start - 32'(close)), 64'd1);
    check({tag, " framing"}, r.framing_ok, 1'b1);
    check({tag, " busy"}, r.busy_ok, 1'b1);
    check({tag, " frame_cnt"}, frame_cnt, exp_fc[7:0]);
  endtask

  task automatic expect_none(input string tag, input int ncyc);
    repeat (ncyc) @(negedge clk);
    check({tag, " no frame"}, 64'(got_q.size()), 64'd0);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " frame_cnt"}, frame_cnt, exp_fc[7:0]);
    got_q.delete();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check({tag, " tx"}, tx, 1'b1);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " frame_cnt"}, frame_cnt, 8'd0);
    check({tag, " overrun"}, overrun, 1'b0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    exp_fc = 0;
    got_q.delete();
  endtask

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[3];
    int   c1, c2, c3;
    int   bad_tx, bad_busy, bad_ovr, bad_fc;
    win_t wa, wb, acc;
    int   k;
    logic en, vld;
    logic [7:0] v;

    vecs[0] = '{s: mk(8'd10, 8'd20, 8'd30, 8'd40),     exp: 40'hA5_19_0A_28_9E};
    vecs[1] = '{s: mk(8'd255, 8'd255, 8'd255, 8'd254), exp: 40'hA5_FE_FE_FF_5A};
    vecs[2] = '{s: mk(8'd0, 8'd0, 8'd0, 8'd0),         exp: 40'hA5_00_00_00_A5};

    // Reset state and 100 idle cycles
    repeat (3) @(negedge clk);
    check("reset tx", tx, 1'b1);
    check("reset busy", busy, 1'b0);
    rst_n = 1'b1;
    bad_tx = 0; bad_busy = 0; bad_ovr = 0; bad_fc = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
      if (overrun !== 1'b0) bad_ovr++;
      if (frame_cnt !== 8'd0) bad_fc++;
    end
    check("idle tx cycles", 64'(bad_tx), 64'd0);
    check("idle busy cycles", 64'(bad_busy), 64'd0);
    check("idle overrun cycles", 64'(bad_ovr), 64'd0);
    check("idle frame_cnt cycles", 64'(bad_fc), 64'd0);

    // Table-driven windows
    for (int i = 0; i < 3; i++) begin
      send_window(vecs[i].s, c1);
      expect_frame($sformatf("vec%0d", i), vecs[i].exp, c1);
    end
    check("table overrun", overrun, 1'b0);

    // Window closes while busy: dropped, overrun sticky
    wa = mk(8'd5, 8'd6, 8'd7, 8'd8);
    send_window(wa, c1);
    send_window(mk(8'd100, 8'd100, 8'd100, 8'd100), c2);
    expect_frame("ovr first", model(wa), c1);
    check("ovr set", overrun, 1'b1);
    expect_none("ovr dropped", 60);
    wb = mk(8'd200, 8'd3, 8'd77, 8'd150);
    send_window(wb, c3);
    expect_frame("after ovr", model(wb), c3);
    check("ovr sticky", overrun, 1'b1);

    // Close on the final stop-bit cycle counts as busy
    do_reset("rst1");
    send_window(wa, c1);
    wait_until(c1 + FRAME - 4);
    send_window(wb, c2);
    check("edge close cycle", 64'(c2 - c1), 64'(FRAME + 1));
    expect_frame("edge A", model(wa), c1);
    expect_none("edge B dropped", 60);
    check("edge ovr", overrun, 1'b1);

    // One cycle later the FSM is idle and the window is sent back-to-back
    do_reset("rst2");
    send_window(wa, c1);
    wait_until(c1 + FRAME - 3);
    send_window(wb, c2);
    expect_frame("b2b A", model(wa), c1);
    expect_frame("b2b B", model(wb), c2);
    check("b2b ovr", overrun, 1'b0);

    // ena low blocks acceptance; a partial window is held across ena gaps
    for (int i = 0; i < 8; i++) drive(8'($urandom), 1'b0, 1'b1);
    finish_drive(c1);
    expect_none("ena0", 30);
    drive(8'd1, 1'b1, 1'b1);
    drive(8'd2, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(8'($urandom), 1'b0, 1'b1);
    drive(8'd3, 1'b1, 1'b1);
    drive(8'd4, 1'b1, 1'b1);
    finish_drive(c1);
    expect_frame("ena hold", 40'hA5_02_01_04_A2, c1);

    // Random windows with random ena / valid gaps
    for (int w = 0; w < 8; w++) begin
      k = 0;
      while (k < NS) begin
        en  = ($urandom_range(0, 3) != 0);
        vld = ($urandom_range(0, 3) != 0);
        v   = 8'($urandom);
        drive(v, en, vld);
        if (en && vld) begin
          acc[k] = v;
          k++;
        end
      end
      finish_drive(c1);
      expect_frame($sformatf("rand%0d", w), model(acc), c1);
    end

    // Asynchronous reset in the middle of byte 2 data bits
    send_window(wb, c1);
    wait_until(c1 + 1 + 90);
    check("mid busy before rst", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid rst tx", tx, 1'b1);
    check("mid rst busy", busy, 1'b0);
    check("mid rst frame_cnt", frame_cnt, 8'd0);
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    exp_fc = 0;
    got_q.delete();
    send_window(wa, c2);
    expect_frame("after mid rst", model(wa), c2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/telemetry_uart_packetizer.md
# telemetry_uart_packetizer

Windowed statistics and UART telemetry stage, downstream of the converter datapath in `tt_um_vedm_industries`. It consumes the 8-bit converted power/voltage sample stream and accumulates a window of 2^WINDOW_LOG2 samples into average, min and max. Each completed window is serialised as a 5-byte 8N1 UART frame on one output pin for off-chip logging.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- `WINDOW_LOG2`, 4: log2 of samples per window (16); legal range 1..7.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst_n`  input  1  reset, asynchronous assert, active-low.
- `ena`  input  1  sample-accept enable; low = samples ignored.
- `sample_in`  input  8  unsigned converted sample.
- `sample_valid`  input  1  single-cycle qualifier for `sample_in`.
- `tx`  output  1  UART serial out, idle high.
- `busy`  output  1  high while a frame is being transmitted.
- `overrun`  output  1  sticky: a window completed while busy.
- `frame_cnt`  output  8  count of fully transmitted frames, wraps.

## Operation
- Sample accepted when `ena && sample_valid`.
- Accumulator sum is 8+WINDOW_LOG2 bits and cannot overflow. Running min and max start at the first sample of each window.
- Sample counter counts 0..2^W−1.
- On acceptance of the 2^W-th sample, the window closes:
  - avg = sum >> WINDOW_LOG2 (truncating); min and max include this sample.
  - Sum, count, min and max restart on the same edge; the next accepted sample opens a new window.
- Closed window with TX FSM in IDLE that cycle: snapshot {0xA5, avg, min, max, chk} is loaded and transmission starts. chk = 0xA5 ^ avg ^ min ^ max.
- Closed window with TX FSM not in IDLE (including the final stop-bit cycle): snapshot discarded and `overrun` set. `overrun` is cleared only by reset.
- TX FSM states and transitions:
  - IDLE: tx=1.
  - START: tx=0 → DATA.
  - DATA: 8 bits, LSB first → STOP.
  - STOP: tx=1. Goes to START if byte index < 4, else IDLE with `frame_cnt` +1.
- Byte index runs 0..4. There is no idle gap between bytes.
- Deasserting `ena` mid-frame does not abort transmission; it only blocks sample acceptance. A partial window is held, not cleared.
- `frame_cnt` wraps 255→0.

## Timing
- Reset (async): tx=1, busy=0, overrun=0, frame_cnt=0, FSM=IDLE, accumulators cleared. Applies immediately, mid-frame included.
- Window-close edge E:
  - `busy` rises and `tx` drops to the start bit at E+1 (registered outputs).
- Each bit lasts exactly CLKS_PER_BIT cycles.
- Frame length is 50×CLKS_PER_BIT cycles. `busy` is high for exactly that many cycles.
- `frame_cnt` increments on the same edge that `busy` falls.
- Back-to-back samples (valid every cycle) are supported. Minimum window-close spacing is 2^W cycles.
- No backpressure to the upstream stage; the drop policy is the overrun rule above.

## Test plan
Sim parameters: CLKS_PER_BIT=4, WINDOW_LOG2=2.
- Reset release, no samples → tx=1, busy=0, overrun=0, frame_cnt=0 held for 100 cycles.
- Samples 10,20,30,40 (valid every cycle) → bytes A5,19,0A,28,9E decoded from tx LSB-first. busy high for 200 cycles; frame_cnt=1.
- Samples 255,255,255,254 → avg truncates to FE; frame A5,FE,FE,FF,5A.
- While busy with frame 1, feed 4 more samples → overrun=1, no second frame, frame_cnt stays 1. A further window after idle is transmitted normally.
- ena=0 with 8 valid samples → no frame, busy stays 0. Then ena=1 and 4 samples 1,2,3,4 → frame A5,02,01,04,A2.
- Assert rst_n=0 during DATA of byte 2 → tx=1 and busy=0 asynchronously, frame_cnt=0. After release the next window yields a complete frame.
